// File: rtl/uart_pkg.sv
// Shared constants and types for the buffered UART register block.
package uart_pkg;

  localparam int unsigned UART_OFS_W = 5;

  // Register offsets relative to BASE_ADDR
  localparam logic [UART_OFS_W-1:0] UART_STATUS_OFS = 5'h00;
  localparam logic [UART_OFS_W-1:0] UART_RECV_OFS   = 5'h04;
  localparam logic [UART_OFS_W-1:0] UART_TRANS_OFS  = 5'h08;
  localparam logic [UART_OFS_W-1:0] UART_LEVEL_OFS  = 5'h0C;
  localparam logic [UART_OFS_W-1:0] UART_IRQ_EN_OFS = 5'h10;
  localparam logic [UART_OFS_W-1:0] UART_CTRL_OFS   = 5'h14;

  // STATUS bit positions
  localparam int unsigned ST_TX_NOT_FULL  = 0;
  localparam int unsigned ST_RX_NOT_EMPTY = 1;
  localparam int unsigned ST_TX_IDLE      = 2;
  localparam int unsigned ST_RX_OVF       = 3;
  localparam int unsigned ST_TX_OVF       = 4;
  localparam int unsigned ST_W            = 5;

  // IRQ_EN bit positions
  localparam int unsigned IE_RX_NOT_EMPTY = 0;
  localparam int unsigned IE_TX_EMPTY     = 1;
  localparam int unsigned IE_OVF          = 2;
  localparam int unsigned IE_W            = 3;

  // CTRL write-1 action bit positions
  localparam int unsigned CTRL_CLR_RX_OVF = 0;
  localparam int unsigned CTRL_CLR_TX_OVF = 1;
  localparam int unsigned CTRL_FLUSH_RX   = 2;
  localparam int unsigned CTRL_FLUSH_TX   = 3;

  typedef struct packed {
    logic tx_ovf;
    logic rx_ovf;
    logic tx_idle;
    logic rx_not_empty;
    logic tx_not_full;
  } uart_status_t;

endpackage

// File: rtl/uart.sv
// 8N1 serial core with valid/ready byte interfaces.
module uart #(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  input  logic       serial_rx,
  output logic       serial_tx
);

  localparam int unsigned DIV   = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W = $clog2(DIV + 1);

  logic             tx_busy;
  logic [9:0]       tx_shift;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bit;

  logic             rx_meta;
  logic             rx_s;
  logic             rx_busy;
  logic [CNT_W-1:0] rx_cnt;
  logic [3:0]       rx_bit;
  logic [7:0]       rx_shift;

  assign data_in_ready = !tx_busy;
  assign serial_tx     = tx_shift[0];

  // Transmitter: load start/data/stop frame, shift one bit per baud period
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      tx_shift <= '1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else if (!tx_busy) begin
      if (data_in_valid) begin
        tx_shift <= {1'b1, data_in, 1'b0};
        tx_busy  <= 1'b1;
        tx_cnt   <= '0;
        tx_bit   <= '0;
      end
    end else if (tx_cnt == CNT_W'(DIV - 1)) begin
      tx_cnt   <= '0;
      tx_shift <= {1'b1, tx_shift[9:1]};
      tx_bit   <= tx_bit + 4'd1;
      if (tx_bit == 4'd9) tx_busy <= 1'b0;
    end else begin
      tx_cnt <= tx_cnt + CNT_W'(1);
    end
  end

  // Receive line synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= serial_rx;
      rx_s    <= rx_meta;
    end
  end

  // Receiver: sample mid-bit, reject false starts, drop frames with bad stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_busy        <= 1'b0;
      rx_cnt         <= '0;
      rx_bit         <= '0;
      rx_shift       <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      if (data_out_valid && data_out_ready) data_out_valid <= 1'b0;
      if (!rx_busy) begin
        if (!rx_s) begin
          rx_busy <= 1'b1;
          rx_cnt  <= CNT_W'(DIV / 2);
          rx_bit  <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - CNT_W'(1);
      end else begin
        rx_cnt <= CNT_W'(DIV - 1);
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) begin
          if (rx_s) rx_busy <= 1'b0;
        end else if (rx_bit <= 4'd8) begin
          rx_shift <= {rx_s, rx_shift[7:1]};
        end else begin
          rx_busy <= 1'b0;
          if (rx_s) begin
            data_out       <= rx_shift;
            data_out_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with registered full/empty/count and a synchronous flush.
module uart_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               head_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;
  logic [CW-1:0] count_nxt;

  // Full/empty come from registered state, so a push into a full FIFO drops even with a pop
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign head_c  = mem[rd_ptr];

  // Next occupancy
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy flags
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_fifo_wrap.sv
// Memory-mapped UART with TX/RX byte FIFOs, sticky overflow flags and maskable IRQ.
module uart_fifo_wrap
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned TX_DEPTH   = 16,
  parameter int unsigned RX_DEPTH   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_uart_addr,
  input  logic        i_uart_write,
  input  logic        i_uart_read,
  input  logic [3:0]  i_uart_size,
  input  logic [31:0] i_uart_din,
  output logic [31:0] o_uart_dout,
  input  logic        i_serial_rx,
  output logic        o_serial_tx,
  output logic        o_uart_irq
);

  localparam int unsigned TXC_W = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RXC_W = $clog2(RX_DEPTH) + 1;

  logic [31:0]           ofs;
  logic                  addr_ok;
  logic [UART_OFS_W-1:0] reg_ofs;
  logic                  rd_recv;
  logic                  wr_trans;
  logic                  wr_irq_en;
  logic                  wr_ctrl;
  logic                  flush_tx;
  logic                  flush_rx;

  logic [7:0]       core_din;
  logic             core_din_valid;
  logic             core_din_ready;
  logic [7:0]       core_dout;
  logic             core_dout_valid;

  logic [7:0]       tx_head;
  logic             tx_full;
  logic             tx_empty;
  logic [TXC_W-1:0] tx_count;
  logic [7:0]       rx_head;
  logic             rx_full;
  logic             rx_empty;
  logic [RXC_W-1:0] rx_count;

  logic             rx_ovf;
  logic             tx_ovf;
  logic [IE_W-1:0]  irq_en;
  logic             read_q;
  logic [31:0]      rdata_q;
  logic [31:0]      rd_val;
  logic [ST_W-1:0]  status_vec;
  uart_status_t     status;
  logic             unused_bits;

  // Address decode: in-window, word-aligned offsets only
  assign ofs       = i_uart_addr - BASE_ADDR;
  assign addr_ok   = (ofs[31:UART_OFS_W] == '0) && (ofs[1:0] == 2'b00);
  assign reg_ofs   = ofs[UART_OFS_W-1:0];
  assign rd_recv   = i_uart_read  && addr_ok && (reg_ofs == UART_RECV_OFS);
  assign wr_trans  = i_uart_write && addr_ok && (reg_ofs == UART_TRANS_OFS);
  assign wr_irq_en = i_uart_write && addr_ok && (reg_ofs == UART_IRQ_EN_OFS);
  assign wr_ctrl   = i_uart_write && addr_ok && (reg_ofs == UART_CTRL_OFS);
  assign flush_tx  = wr_ctrl && i_uart_din[CTRL_FLUSH_TX];
  assign flush_rx  = wr_ctrl && i_uart_din[CTRL_FLUSH_RX];

  assign core_din_valid = !tx_empty;
  assign core_din       = tx_head;
  assign unused_bits    = &{1'b0, i_uart_size, i_uart_din[31:8]};

  uart_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk    (i_clk),
    .rst    (i_rst),
    .flush  (flush_tx),
    .push   (wr_trans),
    .din    (i_uart_din[7:0]),
    .pop    (core_din_valid && core_din_ready),
    .head_c (tx_head),
    .full   (tx_full),
    .empty  (tx_empty),
    .count  (tx_count)
  );

  uart_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk    (i_clk),
    .rst    (i_rst),
    .flush  (flush_rx),
    .push   (core_dout_valid),
    .din    (core_dout),
    .pop    (rd_recv),
    .head_c (rx_head),
    .full   (rx_full),
    .empty  (rx_empty),
    .count  (rx_count)
  );

  uart #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_uart (
    .clk            (i_clk),
    .rst            (i_rst),
    .data_in        (core_din),
    .data_in_valid  (core_din_valid),
    .data_in_ready  (core_din_ready),
    .data_out       (core_dout),
    .data_out_valid (core_dout_valid),
    .data_out_ready (1'b1),
    .serial_rx      (i_serial_rx),
    .serial_tx      (o_serial_tx)
  );

  // STATUS assembly
  always_comb begin
    status_vec                  = '0;
    status_vec[ST_TX_NOT_FULL]  = !tx_full;
    status_vec[ST_RX_NOT_EMPTY] = !rx_empty;
    status_vec[ST_TX_IDLE]      = tx_empty && core_din_ready;
    status_vec[ST_RX_OVF]       = rx_ovf;
    status_vec[ST_TX_OVF]       = tx_ovf;
  end
  assign status = uart_status_t'(status_vec);

  // Read data mux; unmapped, misaligned and write-only offsets read as 0
  always_comb begin
    rd_val = '0;
    if (addr_ok) begin
      case (reg_ofs)
        UART_STATUS_OFS: rd_val = 32'(status);
        UART_RECV_OFS:   rd_val = {24'b0, rx_empty ? 8'h00 : rx_head};
        UART_LEVEL_OFS:  rd_val = {16'b0, 8'(rx_count), 8'(tx_count)};
        UART_IRQ_EN_OFS: rd_val = 32'(irq_en);
        default:         rd_val = '0;
      endcase
    end
  end

  assign o_uart_dout = read_q ? rdata_q : '0;

  // Sticky flags (set beats clear), IRQ enable, registered IRQ and read data
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_ovf     <= 1'b0;
      tx_ovf     <= 1'b0;
      irq_en     <= '0;
      o_uart_irq <= 1'b0;
      read_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (wr_ctrl && i_uart_din[CTRL_CLR_RX_OVF]) rx_ovf <= 1'b0;
      if (core_dout_valid && rx_full && !flush_rx) rx_ovf <= 1'b1;
      if (wr_ctrl && i_uart_din[CTRL_CLR_TX_OVF]) tx_ovf <= 1'b0;
      if (wr_trans && tx_full && !flush_tx) tx_ovf <= 1'b1;
      if (wr_irq_en) irq_en <= i_uart_din[IE_W-1:0];
      o_uart_irq <= |(irq_en & {rx_ovf | tx_ovf, tx_empty, !rx_empty});
      read_q     <= i_uart_read;
      rdata_q    <= i_uart_read ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_uart_fifo_wrap.sv
// Directed bench for uart_fifo_wrap: register map, FIFO boundaries, IRQ and flush.
module tb_uart_fifo_wrap;

  localparam int unsigned CLK_HZ = 16_000_000;
  localparam int unsigned BAUD   = 1_000_000;
  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned TXD    = 16;
  localparam int unsigned RXD    = 16;
  localparam logic [31:0] BASE   = 32'h8000_0000;

  localparam logic [31:0] A_STATUS = 32'h00;
  localparam logic [31:0] A_RECV   = 32'h04;
  localparam logic [31:0] A_TRANS  = 32'h08;
  localparam logic [31:0] A_LEVEL  = 32'h0C;
  localparam logic [31:0] A_IRQ_EN = 32'h10;
  localparam logic [31:0] A_CTRL   = 32'h14;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_uart_addr;
  logic        i_uart_write;
  logic        i_uart_read;
  logic [3:0]  i_uart_size;
  logic [31:0] i_uart_din;
  logic [31:0] o_uart_dout;
  logic        i_serial_rx;
  logic        o_serial_tx;
  logic        o_uart_irq;

  int checks = 0;
  int errors = 0;

  uart_fifo_wrap #(
    .CLOCK_FREQ (CLK_HZ),
    .BAUD_RATE  (BAUD),
    .BASE_ADDR  (BASE),
    .TX_DEPTH   (TXD),
    .RX_DEPTH   (RXD)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_uart_addr  (i_uart_addr),
    .i_uart_write (i_uart_write),
    .i_uart_read  (i_uart_read),
    .i_uart_size  (i_uart_size),
    .i_uart_din   (i_uart_din),
    .o_uart_dout  (o_uart_dout),
    .i_serial_rx  (i_serial_rx),
    .o_serial_tx  (o_serial_tx),
    .o_uart_irq   (o_uart_irq)
  );

  always #5 i_clk = ~i_clk;

  task automatic bus_write(input logic [31:0] ofs, input logic [31:0] data);
    @(negedge i_clk);
    i_uart_addr  = BASE + ofs;
    i_uart_din   = data;
    i_uart_write = 1'b1;
    @(posedge i_clk);
    #1 i_uart_write = 1'b0;
  endtask

  task automatic bus_read_abs(input logic [31:0] addr, output logic [31:0] data);
    @(negedge i_clk);
    i_uart_addr = addr;
    i_uart_read = 1'b1;
    @(posedge i_clk);
    #1 i_uart_read = 1'b0;
    data = o_uart_dout;
  endtask

  task automatic bus_read(input logic [31:0] ofs, output logic [31:0] data);
    bus_read_abs(BASE + ofs, data);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clk);
    i_serial_rx = 1'b0;
    repeat (DIV) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      i_serial_rx = b[i];
      repeat (DIV) @(negedge i_clk);
    end
    i_serial_rx = 1'b1;
    repeat (DIV) @(negedge i_clk);
  endtask

  task automatic rx_frame(output logic [7:0] b, output logic ok);
    int n;
    n  = 0;
    ok = 1'b1;
    b  = '0;
    @(negedge i_clk);
    while (o_serial_tx !== 1'b0 && n < 20 * DIV) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 20 * DIV) begin
      ok = 1'b0;
    end else begin
      repeat (DIV / 2) @(negedge i_clk);
      if (o_serial_tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge i_clk);
        b[i] = o_serial_tx;
      end
      repeat (DIV) @(negedge i_clk);
      if (o_serial_tx !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    i_rst = 1'b1;
    repeat (4) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_uart_dout !== 32'h0 || o_uart_irq !== 1'b0 || o_serial_tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: got dout=%h irq=%b tx=%b expected dout=0 irq=0 tx=1",
               o_uart_dout, o_uart_irq, o_serial_tx);
    end
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'h5) begin errors++; $display("FAIL reset_status: got %h expected 00000005", d); end
    bus_read(A_LEVEL, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_level: got %h expected 00000000", d); end
  endtask

  task automatic test_unmapped;
    logic [31:0] d;
    bus_read_abs(BASE + 32'h18, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", d); end
    bus_read_abs(BASE + 32'h1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL misaligned_read: got %h expected 0", d); end
    bus_read_abs(BASE - 32'h4, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL below_base_read: got %h expected 0", d); end
    bus_read(A_TRANS, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL trans_read: got %h expected 0", d); end
    bus_write(32'h18, 32'hFFFF_FFFF);
    bus_write(A_TRANS + 32'h2, 32'h0000_00AA);
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'h5) begin errors++; $display("FAIL ignored_write_status: got %h expected 5", d); end
    @(posedge i_clk);
    #1;
    checks++;
    if (o_uart_dout !== 32'h0) begin errors++; $display("FAIL dout_idle: got %h expected 0", o_uart_dout); end
  endtask

  task automatic test_tx_basic;
    logic [31:0] d;
    logic [7:0]  b;
    logic        ok;
    logic [7:0]  exp_b [3];
    exp_b = '{8'h55, 8'hA3, 8'h0F};
    fork
      begin
        bus_write(A_TRANS, 32'h55);
        bus_write(A_TRANS, 32'hA3);
        bus_write(A_TRANS, 32'h0F);
        bus_read(A_LEVEL, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL tx_level_peak: got %h expected 2", d); end
      end
      begin
        for (int i = 0; i < 3; i++) begin
          rx_frame(b, ok);
          checks++;
          if (!ok || b !== exp_b[i]) begin
            errors++;
            $display("FAIL tx_frame%0d: got %h ok=%b expected %h", i, b, ok, exp_b[i]);
          end
        end
      end
    join
    repeat (2 * DIV) @(posedge i_clk);
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'h5) begin errors++; $display("FAIL tx_idle_after: got %h expected 5", d); end
  endtask

  task automatic test_tx_overflow;
    logic [31:0] d;
    logic [7:0]  b;
    logic        ok;
    bus_write(A_TRANS, 32'hFF);
    repeat (3) @(posedge i_clk);
    for (int i = 0; i < TXD + 3; i++) bus_write(A_TRANS, 32'(8'h20 + 8'(i)));
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'h10) begin errors++; $display("FAIL tx_ovf_status: got %h expected 10", d); end
    bus_read(A_LEVEL, d);
    checks++;
    if (d !== 32'(TXD)) begin errors++; $display("FAIL tx_full_level: got %h expected %h", d, TXD); end
    bus_write(A_CTRL, 32'h2);
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL tx_ovf_clear: got %h expected 0", d); end
    for (int i = 0; i < TXD; i++) begin
      rx_frame(b, ok);
      checks++;
      if (!ok || b !== 8'(8'h20 + 8'(i))) begin
        errors++;
        $display("FAIL tx_ovf_frame%0d: got %h ok=%b expected %h", i, b, ok, 8'(8'h20 + 8'(i)));
      end
    end
    repeat (2 * DIV) @(posedge i_clk);
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'h5) begin errors++; $display("FAIL tx_drained_status: got %h expected 5", d); end
  endtask

  task automatic test_rx_overflow;
    logic [31:0] d;
    for (int i = 0; i <= RXD; i++) send_byte(8'(i));
    repeat (2 * DIV) @(posedge i_clk);
    bus_read(A_LEVEL, d);
    checks++;
    if (d !== 32'(RXD) << 8) begin errors++; $display("FAIL rx_full_level: got %h expected %h", d, 32'(RXD) << 8); end
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'hF) begin errors++; $display("FAIL rx_ovf_status: got %h expected f", d); end
    for (int i = 0; i < RXD + 2; i++) begin
      bus_read(A_RECV, d);
      checks++;
      if (d !== ((i < RXD) ? 32'(i) : 32'h0)) begin
        errors++;
        $display("FAIL rx_recv%0d: got %h expected %h", i, d, (i < RXD) ? 32'(i) : 32'h0);
      end
    end
    bus_read(A_LEVEL, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rx_empty_level: got %h expected 0", d); end
    bus_write(A_CTRL, 32'h1);
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'h5) begin errors++; $display("FAIL rx_ovf_clear: got %h expected 5", d); end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    logic        prev;
    logic        seen;
    int          n;
    bus_write(A_IRQ_EN, 32'h1);
    bus_read(A_IRQ_EN, d);
    checks++;
    if (d !== 32'h1 || o_uart_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_en_readback: got %h irq=%b expected 1 irq=0", d, o_uart_irq);
    end
    seen = 1'b0;
    fork
      send_byte(8'h7E);
      begin
        n    = 0;
        prev = o_uart_irq;
        while (!seen && n < 40 * DIV) begin
          bus_read(A_STATUS, d);
          if (d[1]) begin
            seen = 1'b1;
            checks++;
            if (o_uart_irq !== 1'b1 || prev !== 1'b0) begin
              errors++;
              $display("FAIL irq_rise_timing: got irq=%b prev=%b expected irq=1 prev=0", o_uart_irq, prev);
            end
          end
          prev = o_uart_irq;
          n++;
        end
      end
    join
    checks++;
    if (!seen) begin errors++; $display("FAIL irq_rx_timeout: got none expected rx_not_empty"); end
    bus_read(A_RECV, d);
    checks++;
    if (d !== 32'h7E) begin errors++; $display("FAIL irq_recv: got %h expected 7e", d); end
    @(posedge i_clk);
    #1;
    checks++;
    if (o_uart_irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b expected 0", o_uart_irq); end
    bus_write(A_IRQ_EN, 32'h2);
    @(posedge i_clk);
    #1;
    checks++;
    if (o_uart_irq !== 1'b1) begin errors++; $display("FAIL irq_tx_empty: got %b expected 1", o_uart_irq); end
    bus_write(A_IRQ_EN, 32'h4);
    @(posedge i_clk);
    #1;
    checks++;
    if (o_uart_irq !== 1'b0) begin errors++; $display("FAIL irq_ovf_masked: got %b expected 0", o_uart_irq); end
    bus_write(A_IRQ_EN, 32'h0);
  endtask

  task automatic test_flush;
    logic [31:0] d;
    logic [7:0]  b;
    logic        ok;
    int          lows;
    fork
      begin
        bus_write(A_TRANS, 32'hC1);
        bus_write(A_TRANS, 32'hC2);
        bus_write(A_TRANS, 32'hC3);
        bus_write(A_TRANS, 32'hC4);
        bus_write(A_TRANS, 32'hC5);
        bus_write(A_CTRL, 32'h8);
        bus_read(A_LEVEL, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL flush_level: got %h expected 0", d); end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL flush_status: got %h expected 1", d); end
      end
      begin
        rx_frame(b, ok);
        checks++;
        if (!ok || b !== 8'hC1) begin errors++; $display("FAIL flush_inflight: got %h ok=%b expected c1", b, ok); end
      end
    join
    lows = 0;
    repeat (30 * DIV) begin
      @(negedge i_clk);
      if (o_serial_tx !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL flush_line_quiet: got %0d low cycles expected 0", lows); end
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'h5) begin errors++; $display("FAIL flush_final_status: got %h expected 5", d); end
  endtask

  initial begin
    i_rst        = 1'b1;
    i_uart_addr  = '0;
    i_uart_write = 1'b0;
    i_uart_read  = 1'b0;
    i_uart_size  = 4'h2;
    i_uart_din   = '0;
    i_serial_rx  = 1'b1;
    test_reset();
    test_unmapped();
    test_tx_basic();
    test_tx_overflow();
    test_rx_overflow();
    test_irq();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
